// File: rtl/nes_bus_pkg.sv
// Shared encodings for the NES sprite-DMA bus arbiter: FSM states,
// CPU-clock parity values and shared-bus owner select.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_ALIGN   = 3'd2,
        ST_GRANT   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic PAR_EVEN    = 1'b0;
    localparam logic PAR_ODD     = 1'b1;

    localparam logic BUS_SEL_CPU = 1'b0;
    localparam logic BUS_SEL_DMA = 1'b1;

endpackage

// File: rtl/nes_dma_bus_arbiter.sv
// CPU-clock arbiter between the 6502 core and the sprite-DMA master.
// Halts the CPU through RDY, waits out CPU writes (RDY is ignored on
// writes), aligns, then hands the shared bus to DMA until the request
// drops or the grant watchdog fires.
// Optional build macro NES_DMA_ODD_ALIGN_EN: stretch ALIGN so the first
// GRANT cycle always falls on an even ("get") CPU cycle.
module nes_dma_bus_arbiter
    import nes_bus_pkg::*;
#(
    parameter int MAX_GNT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_wn,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_rdy,
    output logic [7:0]  o_cpu_rdata,
    input  logic        i_dma_req,
    output logic        o_dma_gnt,
    input  logic [15:0] i_dma_addr,
    input  logic        i_dma_wn,
    input  logic [7:0]  i_dma_wdata,
    output logic [7:0]  o_dma_rdata,
    output logic [15:0] o_bus_addr,
    output logic        o_bus_wn,
    output logic [7:0]  o_bus_wdata,
    input  logic [7:0]  i_bus_rdata,
    output logic        o_busy,
    output logic        o_wdog_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_GNT_CYCLES - 1);

    state_t           r_state;
    logic             r_cpu_rdy;
    logic             r_dma_gnt;
    logic             r_bus_sel;
    logic             r_wdog_err;
    logic [CNT_W-1:0] r_cnt;
    logic             w_align_done;

`ifdef NES_DMA_ODD_ALIGN_EN
    logic             r_par;

    // CPU-cycle parity, 0 on the first cycle after reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_par <= PAR_EVEN;
        else         r_par <= ~r_par;
    end

    // Leaving ALIGN from an odd cycle makes the first GRANT cycle even.
    assign w_align_done = (r_par == PAR_ODD);
`else
    assign w_align_done = 1'b1;
`endif

    // Arbitration FSM with registered RDY, grant, bus select and watchdog
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_cpu_rdy  <= 1'b1;
            r_dma_gnt  <= 1'b0;
            r_bus_sel  <= BUS_SEL_CPU;
            r_wdog_err <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_dma_req) begin
                        r_state   <= ST_HALT;
                        r_cpu_rdy <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (!i_dma_req)    r_state <= ST_RELEASE;
                    else if (i_cpu_wn) r_state <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (!i_dma_req) begin
                        r_state <= ST_RELEASE;
                    end else if (w_align_done) begin
                        r_state   <= ST_GRANT;
                        r_dma_gnt <= 1'b1;
                        r_bus_sel <= BUS_SEL_DMA;
                        r_cnt     <= '0;
                    end
                end
                ST_GRANT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!i_dma_req || (r_cnt == CNT_LAST)) begin
                        r_state   <= ST_RELEASE;
                        r_dma_gnt <= 1'b0;
                        r_bus_sel <= BUS_SEL_CPU;
                        if (i_dma_req) r_wdog_err <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state   <= ST_IDLE;
                    r_cpu_rdy <= 1'b1;
                    r_cnt     <= '0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cpu_rdy <= 1'b1;
                    r_dma_gnt <= 1'b0;
                    r_bus_sel <= BUS_SEL_CPU;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    // Shared-bus mux driven only from the registered owner select
    always_comb begin
        o_bus_addr  = i_cpu_addr;
        o_bus_wn    = i_cpu_wn;
        o_bus_wdata = i_cpu_wdata;
        if (r_bus_sel == BUS_SEL_DMA) begin
            o_bus_addr  = i_dma_addr;
            o_bus_wn    = i_dma_wn;
            o_bus_wdata = i_dma_wdata;
        end
    end

    assign o_cpu_rdy   = r_cpu_rdy;
    assign o_dma_gnt   = r_dma_gnt;
    assign o_wdog_err  = r_wdog_err;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_cpu_rdata = i_bus_rdata;
    assign o_dma_rdata = i_bus_rdata;

endmodule
